// File: rtl/noc_traffic_endpoint_if.sv
// rtl/noc_traffic_endpoint_if.sv - flit link between a traffic endpoint and its router local port
interface noc_traffic_endpoint_if;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;

  // Endpoint side: drives tx flits, sinks rx flits
  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  // Router side
  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/noc_traffic_endpoint.sv
// rtl/noc_traffic_endpoint.sv - per-node VC packet generator and receive checker (optional checker: RX_CHECK_EN)
module noc_traffic_endpoint #(
  parameter int ID    = 0,
  parameter int DIM   = 3,
  parameter int VC    = 4,
  parameter int FLITS = 16,
  parameter int PKT_W = 12,
  parameter int GAP_W = 8,
  localparam int VSW  = (VC > 1) ? $clog2(VC) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            cfg_dest,
  input  logic [1:0]            cfg_prio,
  input  logic [GAP_W-1:0]      cfg_gap,
  input  logic [PKT_W-1:0]      cfg_npkts,
  input  logic [VSW-1:0]        vc_sel,
  noc_traffic_endpoint_if.master link,
  output logic [VC*PKT_W-1:0]   sent_cnt,
  output logic [VC*PKT_W-1:0]   recv_cnt,
  output logic [15:0]           err_cnt,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, HEAD, BODY, TAIL, GAP, DONE} state_t;

  localparam logic [3:0] SRC_ROW = 4'(ID / DIM);
  localparam logic [3:0] SRC_COL = 4'(ID % DIM);

  state_t             state   [VC];
  logic [PKT_W-1:0]   msg_id  [VC];
  logic [15:0]        seq     [VC];
  logic [GAP_W-1:0]   gap_cnt [VC];
  logic [PKT_W-1:0]   sent    [VC];
  logic [PKT_W-1:0]   recv    [VC];
  logic [31:0]        flit    [VC];
  logic [VC-1:0]      vld;
  logic [VC-1:0]      adv;
  logic [VC-1:0]      in_done;
  logic               vc_ok;
  logic               rx_fire;
  logic [1:0]         rx_type;

  assign vc_ok         = int'(vc_sel) < VC;
  assign rx_fire       = link.rx_valid & link.rx_ready;
  assign rx_type       = link.rx_data[31:30];
  assign link.rx_ready = ~rst;

  // Build each VC's current flit from its registered state; flit only changes after its own transfer
  always_comb begin
    for (int v = 0; v < VC; v++) begin
      vld[v]     = 1'b0;
      flit[v]    = '0;
      in_done[v] = (state[v] == DONE);
      adv[v]     = link.tx_valid & link.tx_ready & vc_ok & (int'(vc_sel) == v);
      case (state[v])
        HEAD: begin
          vld[v]  = 1'b1;
          flit[v] = {2'b01, cfg_prio, msg_id[v], SRC_COL, SRC_ROW, cfg_dest};
        end
        BODY: begin
          vld[v]  = 1'b1;
          flit[v] = {2'b10, cfg_prio, msg_id[v], seq[v]};
        end
        TAIL: begin
          vld[v]  = 1'b1;
          flit[v] = {2'b11, cfg_prio, msg_id[v], SRC_COL, SRC_ROW, cfg_dest};
        end
        default: ;
      endcase
    end
  end

  // The plane selector picks which VC owns the physical link this cycle
  always_comb begin
    link.tx_valid = 1'b0;
    link.tx_data  = '0;
    if (vc_ok) begin
      link.tx_valid = vld[vc_sel];
      link.tx_data  = flit[vc_sel];
    end
  end

  // Per-VC generator FSMs; a VC only advances on a transfer while it owns the link
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC; v++) begin
        state[v]   <= IDLE;
        msg_id[v]  <= '0;
        seq[v]     <= '0;
        gap_cnt[v] <= '0;
        sent[v]    <= '0;
      end
    end else begin
      for (int v = 0; v < VC; v++) begin
        case (state[v])
          IDLE: if (start && cfg_npkts != '0) state[v] <= HEAD;
          HEAD: if (adv[v]) begin
            seq[v]   <= 16'd1;
            state[v] <= (FLITS == 2) ? TAIL : BODY;
          end
          BODY: if (adv[v]) begin
            if (seq[v] == 16'(FLITS - 2)) state[v] <= TAIL;
            else seq[v] <= seq[v] + 16'd1;
          end
          TAIL: if (adv[v]) begin
            sent[v]    <= sent[v] + 1'b1;
            msg_id[v]  <= msg_id[v] + 1'b1;
            gap_cnt[v] <= '0;
            if (PKT_W'(sent[v] + 1'b1) == cfg_npkts) state[v] <= DONE;
            else if (cfg_gap == '0 && start)        state[v] <= HEAD;
            else                                     state[v] <= GAP;
          end
          GAP: begin
            if ({1'b0, gap_cnt[v]} + 1'b1 >= {1'b0, cfg_gap}) begin
              if (start) state[v] <= HEAD;
            end else begin
              gap_cnt[v] <= gap_cnt[v] + 1'b1;
            end
          end
          DONE: ;
          default: state[v] <= IDLE;
        endcase
      end
    end
  end

  // Sticky completion flag once every VC has finished
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           done <= 1'b0;
    else if (&in_done) done <= 1'b1;
  end

  // Count received tails against the VC that owns the link
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC; v++) recv[v] <= '0;
    end else if (rx_fire && vc_ok && rx_type == 2'b11) begin
      recv[vc_sel] <= recv[vc_sel] + 1'b1;
    end
  end

  // Flatten per-VC counters onto the packed output buses
  always_comb begin
    for (int v = 0; v < VC; v++) begin
      sent_cnt[v*PKT_W +: PKT_W] = sent[v];
      recv_cnt[v*PKT_W +: PKT_W] = recv[v];
    end
  end

`ifdef RX_CHECK_EN
  logic [VC-1:0] in_pkt;
  logic [15:0]   exp_seq [VC];
  logic          bad;

  // Classify the arriving flit against the owning VC's framing state
  always_comb begin
    bad = 1'b0;
    if (rx_fire && vc_ok) begin
      case (rx_type)
        2'b01:   bad = in_pkt[vc_sel];
        2'b10:   bad = !in_pkt[vc_sel] || (link.rx_data[15:0] != exp_seq[vc_sel]);
        2'b11:   bad = !in_pkt[vc_sel] || (exp_seq[vc_sel] != 16'(FLITS - 1));
        default: bad = 1'b1;
      endcase
    end
  end

  // Framing tracker: any head restarts a packet, any other error drops back to expecting a head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_pkt  <= '0;
      err_cnt <= '0;
      for (int v = 0; v < VC; v++) exp_seq[v] <= '0;
    end else begin
      if (bad && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      if (rx_fire && vc_ok) begin
        case (rx_type)
          2'b01: begin
            in_pkt[vc_sel]  <= 1'b1;
            exp_seq[vc_sel] <= 16'd1;
          end
          2'b10: begin
            if (bad) in_pkt[vc_sel] <= 1'b0;
            else     exp_seq[vc_sel] <= exp_seq[vc_sel] + 16'd1;
          end
          default: in_pkt[vc_sel] <= 1'b0;
        endcase
      end
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_noc_traffic_endpoint.sv
// tb/tb_noc_traffic_endpoint.sv - self-checking bench for noc_traffic_endpoint
module tb_noc_traffic_endpoint;
  localparam int ID    = 4;
  localparam int DIM   = 3;
  localparam int VC    = 4;
  localparam int FLITS = 6;
  localparam int PKT_W = 12;
  localparam int GAP_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [7:0]       cfg_dest;
  logic [1:0]       cfg_prio;
  logic [GAP_W-1:0] cfg_gap;
  logic [PKT_W-1:0] cfg_npkts;
  logic [1:0]       vc_sel;
  logic             tb_ready;
  logic             loop_en;
  logic             inj_valid;
  logic [31:0]      inj_data;
  logic [VC*PKT_W-1:0] sent_cnt;
  logic [VC*PKT_W-1:0] recv_cnt;
  logic [15:0]      err_cnt;
  logic             done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  noc_traffic_endpoint_if ifc ();

  assign ifc.tx_ready = tb_ready;
  assign ifc.rx_valid = loop_en ? (ifc.tx_valid & tb_ready) : inj_valid;
  assign ifc.rx_data  = loop_en ? ifc.tx_data : inj_data;

  noc_traffic_endpoint #(
    .ID(ID), .DIM(DIM), .VC(VC), .FLITS(FLITS), .PKT_W(PKT_W), .GAP_W(GAP_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_dest(cfg_dest), .cfg_prio(cfg_prio),
    .cfg_gap(cfg_gap), .cfg_npkts(cfg_npkts), .vc_sel(vc_sel), .link(ifc),
    .sent_cnt(sent_cnt), .recv_cnt(recv_cnt), .err_cnt(err_cnt), .done(done)
  );

  // Reference flit of packet pkt, position idx (0 = head, FLITS-1 = tail)
  function automatic logic [31:0] exp_flit(input int pkt, input int idx);
    logic [11:0] mid;
    logic [3:0]  col;
    logic [3:0]  row;
    mid = 12'(pkt);
    col = 4'(ID % DIM);
    row = 4'(ID / DIM);
    if (idx == 0)              return {2'b01, cfg_prio, mid, col, row, cfg_dest};
    else if (idx == FLITS - 1) return {2'b11, cfg_prio, mid, col, row, cfg_dest};
    else                       return {2'b10, cfg_prio, mid, 16'(idx)};
  endfunction

  function automatic logic [PKT_W-1:0] cnt_of(input logic [VC*PKT_W-1:0] bus, input int v);
    return bus[v*PKT_W +: PKT_W];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; tb_ready = 1'b0; loop_en = 1'b1;
    inj_valid = 1'b0; inj_data = '0; vc_sel = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; tb_ready = 1'b0; loop_en = 1'b1; inj_valid = 1'b0;
    inj_data = '0; vc_sel = '0; cfg_dest = '0; cfg_prio = '0; cfg_gap = '0; cfg_npkts = '0;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++;
    if (ifc.tx_valid !== 1'b0 || ifc.tx_data !== 32'h0 || done !== 1'b0 || err_cnt !== 16'h0 ||
        sent_cnt !== '0 || recv_cnt !== '0 || ifc.rx_ready !== 1'b0)
      $display("FAIL reset_state: tx_valid=%b tx_data=%h done=%b err=%h sent=%h recv=%h rx_ready=%b",
               ifc.tx_valid, ifc.tx_data, done, err_cnt, sent_cnt, recv_cnt, ifc.rx_ready);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (ifc.rx_ready !== 1'b1) $display("FAIL rx_ready_after_reset: got %b expected 1", ifc.rx_ready);
    else pass_cnt++;
  endtask

  task automatic test_head_format();
    logic [31:0] tail;
    bit got;
    do_reset();
    cfg_prio = 2'd2; cfg_dest = 8'h21; cfg_npkts = 12'd1; cfg_gap = '0;
    vc_sel = 2'd0; tb_ready = 1'b0; start = 1'b1;
    got = 0;
    for (int i = 0; i < 5 && !got; i++) begin
      @(negedge clk); #1;
      if (ifc.tx_valid) got = 1;
    end
    total_cnt++;
    if (!got || ifc.tx_data !== 32'h60001121)
      $display("FAIL head_format: valid=%b got %h expected 60001121", got, ifc.tx_data);
    else pass_cnt++;
    tb_ready = 1'b1;
    got = 0; tail = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); #1;
      if (ifc.tx_valid && ifc.tx_data[31:30] == 2'b11) begin got = 1; tail = ifc.tx_data; end
    end
    total_cnt++;
    if (!got || tail !== 32'hE0001121)
      $display("FAIL tail_format: seen=%b got %h expected e0001121", got, tail);
    else pass_cnt++;
  endtask

  task automatic test_loopback(input bit rnd);
    int pkt [VC];
    int idx [VC];
    int v;
    bit fin;
    int rot;
    do_reset();
    cfg_npkts = rnd ? 12'($urandom_range(1, 3)) : 12'd2;
    cfg_gap   = rnd ? 8'($urandom_range(0, 3)) : 8'd0;
    cfg_prio  = 2'($urandom_range(0, 3));
    cfg_dest  = 8'($urandom_range(0, 255));
    for (int i = 0; i < VC; i++) begin pkt[i] = 0; idx[i] = 0; end
    fin = 0; rot = 0;
    start = 1'b1;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      @(negedge clk);
      vc_sel   = rnd ? 2'($urandom_range(0, 3)) : 2'(rot % VC);
      rot++;
      tb_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (done) fin = 1;
      else if (ifc.tx_valid && tb_ready) begin
        v = int'(vc_sel);
        total_cnt++;
        if (ifc.tx_data !== exp_flit(pkt[v], idx[v]) || pkt[v] >= int'(cfg_npkts))
          $display("FAIL flit_vc%0d_pkt%0d_idx%0d: got %h expected %h", v, pkt[v], idx[v],
                   ifc.tx_data, exp_flit(pkt[v], idx[v]));
        else pass_cnt++;
        idx[v]++;
        if (idx[v] == FLITS) begin idx[v] = 0; pkt[v]++; end
      end
    end
    total_cnt++;
    if (!fin) $display("FAIL done_timeout: done=%b expected 1", done);
    else pass_cnt++;
    for (int i = 0; i < VC; i++) begin
      total_cnt++;
      if (pkt[i] != int'(cfg_npkts) || cnt_of(sent_cnt, i) !== cfg_npkts || cnt_of(recv_cnt, i) !== cfg_npkts)
        $display("FAIL counts_vc%0d: model=%0d sent=%0d recv=%0d expected %0d", i, pkt[i],
                 cnt_of(sent_cnt, i), cnt_of(recv_cnt, i), cfg_npkts);
      else pass_cnt++;
    end
    total_cnt++;
    if (err_cnt !== 16'h0 || ifc.tx_valid !== 1'b0)
      $display("FAIL loopback_idle: err=%0d tx_valid=%b expected 0 0", err_cnt, ifc.tx_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit got;
    do_reset();
    cfg_npkts = 12'd2; cfg_gap = '0;
    cfg_prio = 2'($urandom_range(0, 3)); cfg_dest = 8'($urandom_range(0, 255));
    vc_sel = 2'd1; tb_ready = 1'b1; start = 1'b1;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk); #1;
      if (ifc.tx_valid && ifc.tx_data === exp_flit(0, 3)) begin got = 1; tb_ready = 1'b0; end
    end
    tb_ready = 1'b0;
    total_cnt++;
    if (!got) $display("FAIL bp_reach_seq3: got %h expected %h", ifc.tx_data, exp_flit(0, 3));
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vc_sel = 2'(i % VC);
      #1;
      total_cnt++;
      if (vc_sel == 2'd1) begin
        if (ifc.tx_valid !== 1'b1 || ifc.tx_data !== exp_flit(0, 3))
          $display("FAIL bp_hold_vc1_c%0d: got %h expected %h", i, ifc.tx_data, exp_flit(0, 3));
        else pass_cnt++;
      end else begin
        if (ifc.tx_valid !== 1'b1 || ifc.tx_data !== exp_flit(0, 0))
          $display("FAIL bp_hold_vc%0d_c%0d: got %h expected %h", vc_sel, i, ifc.tx_data, exp_flit(0, 0));
        else pass_cnt++;
      end
    end
    @(negedge clk);
    vc_sel = 2'd1; tb_ready = 1'b1;
    #1;
    total_cnt++;
    if (ifc.tx_data !== exp_flit(0, 3)) $display("FAIL bp_resume_seq3: got %h expected %h", ifc.tx_data, exp_flit(0, 3));
    else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++;
    if (ifc.tx_data !== exp_flit(0, 4)) $display("FAIL bp_resume_seq4: got %h expected %h", ifc.tx_data, exp_flit(0, 4));
    else pass_cnt++;
  endtask

  task automatic test_gap();
    bit seen_tail;
    bit got;
    int idle;
    logic [31:0] nxt;
    do_reset();
    cfg_npkts = 12'd3; cfg_gap = 8'd5;
    cfg_prio = 2'($urandom_range(0, 3)); cfg_dest = 8'($urandom_range(0, 255));
    vc_sel = 2'd0; tb_ready = 1'b1; start = 1'b1;
    seen_tail = 0; got = 0; idle = 0; nxt = '0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk); #1;
      if (!seen_tail) begin
        if (ifc.tx_valid && ifc.tx_data[31:30] == 2'b11) seen_tail = 1;
      end else if (!ifc.tx_valid) idle++;
      else begin got = 1; nxt = ifc.tx_data; end
    end
    total_cnt++;
    if (!got || idle != 5) $display("FAIL gap_idle_cycles: got %0d expected 5", idle);
    else pass_cnt++;
    total_cnt++;
    if (nxt !== exp_flit(1, 0)) $display("FAIL gap_next_head: got %h expected %h", nxt, exp_flit(1, 0));
    else pass_cnt++;
  endtask

  task automatic test_rx_check();
    logic [31:0] fl [5];
    int ex [5];
    fl[0] = {2'b01, 2'b00, 12'd0, 16'h1100};
    fl[1] = {2'b10, 2'b00, 12'd0, 16'd1};
    fl[2] = {2'b10, 2'b00, 12'd0, 16'd3};
    fl[3] = {2'b11, 2'b00, 12'd0, 16'h1100};
    fl[4] = {2'b00, 2'b00, 12'd0, 16'h0000};
`ifdef RX_CHECK_EN
    ex[0] = 0; ex[1] = 0; ex[2] = 1; ex[3] = 2; ex[4] = 3;
`else
    ex[0] = 0; ex[1] = 0; ex[2] = 0; ex[3] = 0; ex[4] = 0;
`endif
    do_reset();
    loop_en = 1'b0; vc_sel = 2'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      inj_data = fl[i]; inj_valid = 1'b1;
      @(negedge clk);
      inj_valid = 1'b0;
      #1;
      total_cnt++;
      if (err_cnt !== 16'(ex[i])) $display("FAIL rx_err_after_flit%0d: got %0d expected %0d", i, err_cnt, ex[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (cnt_of(recv_cnt, 2) !== 12'd1 || cnt_of(recv_cnt, 0) !== 12'd0 ||
        cnt_of(recv_cnt, 1) !== 12'd0 || cnt_of(recv_cnt, 3) !== 12'd0)
      $display("FAIL rx_recv_cnt: got %h expected %h", recv_cnt, {12'd0, 12'd1, 12'd0, 12'd0});
    else pass_cnt++;
    loop_en = 1'b1;
  endtask

  task automatic test_reset_mid_packet();
    bit got;
    do_reset();
    cfg_npkts = 12'd2; cfg_gap = '0;
    cfg_prio = 2'($urandom_range(0, 3)); cfg_dest = 8'($urandom_range(0, 255));
    vc_sel = 2'd0; tb_ready = 1'b1; start = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk); #1;
      if (ifc.tx_valid && ifc.tx_data === exp_flit(1, 2)) got = 1;
    end
    total_cnt++;
    if (!got || cnt_of(sent_cnt, 0) !== 12'd1 || cnt_of(recv_cnt, 0) !== 12'd1)
      $display("FAIL rst_mid_setup: seen=%b sent=%0d recv=%0d expected 1 1", got, cnt_of(sent_cnt, 0), cnt_of(recv_cnt, 0));
    else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    total_cnt++;
    if (ifc.tx_valid !== 1'b0 || ifc.tx_data !== 32'h0 || sent_cnt !== '0 || recv_cnt !== '0 || done !== 1'b0)
      $display("FAIL rst_mid_clear: tx_valid=%b tx_data=%h sent=%h recv=%h done=%b expected all 0",
               ifc.tx_valid, ifc.tx_data, sent_cnt, recv_cnt, done);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0; tb_ready = 1'b0;
    got = 0;
    for (int i = 0; i < 5 && !got; i++) begin
      @(negedge clk); #1;
      if (ifc.tx_valid) got = 1;
    end
    total_cnt++;
    if (!got || ifc.tx_data !== exp_flit(0, 0))
      $display("FAIL rst_mid_restart_head: got %h expected %h", ifc.tx_data, exp_flit(0, 0));
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_head_format();
    test_loopback(1'b0);
    for (int r = 0; r < 4; r++) test_loopback(1'b1);
    test_backpressure();
    test_gap();
    test_rx_check();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/noc_traffic_endpoint.md
Name: noc_traffic_endpoint

Overview:
Synthesizable per-node traffic generator and checker for the VC mesh NoC. It replaces file-driven stimulus with on-chip packet generation on VC virtual channels that share one physical link, time-multiplexed by the plane selector. The receive side sinks flits, counts packets per VC and checks packet framing. One instance sits at each router local port, in simulation or on FPGA.

Parameters:
ID, 0, node index; src_row = ID / DIM, src_col = ID % DIM
DIM, 3, mesh dimension (N = DIM*DIM)
VC, 4, number of virtual channels; range 1..8
FLITS, 16, flits per packet including head and tail; minimum 2
PKT_W, 12, width of packet counters and message id
GAP_W, 8, width of inter-packet gap counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  level; generation runs while high
cfg_dest  in  8  {dst_col[7:4], dst_row[3:0]}
cfg_prio  in  2  priority field of generated packets
cfg_gap  in  GAP_W  idle cycles after each tail, per VC
cfg_npkts  in  PKT_W  packets to send per VC; 0 = none
vc_sel  in  max(1,$clog2(VC))  plane currently owning the link (from the plane controller)
tx_data  out  32  flit to router
tx_valid  out  1  flit valid
tx_ready  in  1  router accepts
rx_data  in  32  flit from router
rx_valid  in  1  flit valid
rx_ready  out  1  endpoint accepts
sent_cnt  out  VC*PKT_W  packed per-VC tails sent
recv_cnt  out  VC*PKT_W  packed per-VC tails received
err_cnt  out  16  framing errors, saturating
done  out  1  all VCs sent cfg_npkts packets

Behaviour:
- Flit format:
  - [31:30] type: 01 head, 10 body, 11 tail.
  - [29:28] priority; [27:16] message id (per-VC packet index).
  - Head/tail: [15:12] src_col, [11:8] src_row, [7:0] cfg_dest.
  - Body: [15:0] flit sequence number 1..FLITS-2.
- Reset: all FSMs go to IDLE; all counters 0; tx_valid=0; tx_data=0; done=0; err_cnt=0. Reset mid-packet abandons the packet; no tail is sent.
- Per-VC generator FSM: IDLE -> HEAD -> BODY -> TAIL -> GAP -> HEAD | DONE.
  - IDLE -> HEAD when start=1 and cfg_npkts != 0.
  - HEAD -> BODY on transfer; goes to TAIL instead if FLITS=2.
  - BODY holds until FLITS-2 body transfers, then -> TAIL.
  - TAIL transfer: sent_cnt[v]++; message id ++; then -> DONE if sent_cnt[v]==cfg_npkts, else -> GAP.
  - GAP counts cfg_gap cycles; cfg_gap=0 means HEAD on the next cycle.
  - start deasserted: current packet completes; FSM then waits in GAP/IDLE.
- tx mux (combinational):
  - tx_valid = valid of VC vc_sel; tx_data = flit of VC vc_sel.
  - Transfer = tx_valid & tx_ready in the same cycle. It advances only VC vc_sel.
  - A VC's flit is held stable until transferred, across any number of vc_sel changes.
  - vc_sel >= VC forces tx_valid=0.
- done = 1 when every VC is in DONE. Sticky until reset.
- rx: rx_ready=1 whenever not in reset; flits are accepted on rx_valid. The arriving flit is attributed to VC vc_sel.
  - recv_cnt[vc_sel]++ on each tail; wraps modulo 2^PKT_W.
- Counters wrap modulo 2^PKT_W, except err_cnt, which saturates at 0xFFFF.
- Simultaneous tx and rx events in the same cycle are independent.

Optional Feature:
RX_CHECK_EN
- Defined: a per-VC receive checker tracks state EXPECT_HEAD / IN_PKT and the expected sequence number. err_cnt increments by exactly 1 per offending flit on any of:
  - body or tail while in EXPECT_HEAD;
  - head while in IN_PKT;
  - body sequence != expected;
  - tail arriving after fewer than FLITS-2 bodies;
  - type 00.
  - After an error the checker resynchronises: a head starts a new packet, anything else returns to EXPECT_HEAD.
- Undefined: no checker; err_cnt is tied to 0; recv_cnt still counts tails.

Test Plan:
1. VC=4, FLITS=4, cfg_npkts=2, cfg_gap=0, tx_ready=1, vc_sel rotating 0..3 each cycle, rx looped back from tx -> 8 packets sent; sent_cnt=recv_cnt=2 per VC; done=1; err_cnt=0.
2. ID=4, DIM=3, cfg_dest=0x21, cfg_prio=2 -> first head on VC0 = 0x60001121; tail = 0xE0001121.
3. tx_ready=0 for 10 cycles during VC1 BODY seq 3, vc_sel toggling 0..3 -> VC1 data stays at seq 3 throughout; the next VC1 transfer is seq 3, followed by seq 4.
4. cfg_gap=5, single VC, tx_ready=1 -> exactly 5 cycles with tx_valid=0 between a tail and the next head.
5. RX_CHECK_EN: inject head, body seq 1, body seq 3, tail on VC2 -> err_cnt increments by 1 at the seq-3 body; the tail increments err_cnt by 1 more; recv_cnt[2] still counts the tail (1).
6. Assert rst mid-BODY -> tx_valid=0 and all counters 0 in the same cycle; after release with start=1, the next flit is a head with message id 0.
